// File: rtl/cc_match_engine.sv
// cc_match_engine: match-3 board engine.
// A board of ROWS x COLS colour cells is loaded in raster order, a list of swap actions is
// buffered, then each action is applied in turn: swap, mark runs of >= 3, clear, apply gravity
// and repeat the mark/clear/gravity cascade until stable. The cleared-cell total is reported.
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   in_valid_1       board-load strobe, in_color is the next raster cell
//   in_valid_2       action strobe, {in_starting_pos, in_action} is buffered
//   out_valid        one-cycle result strobe
//   out_score        cleared-cell total (saturating), zero when out_valid is low
module cc_match_engine #(
  parameter int unsigned ROWS    = 6,
  parameter int unsigned COLS    = 6,
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned NUM_ACT = 10,
  parameter int unsigned SCORE_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_1,
  input  logic               in_valid_2,
  input  logic [COLOR_W-1:0] in_color,
  input  logic [5:0]         in_starting_pos,
  input  logic [1:0]         in_action,
  output logic               out_valid,
  output logic [SCORE_W-1:0] out_score
);

  localparam int unsigned CNT_W = $clog2(ROWS * COLS + 1);
  localparam int unsigned ACT_W = $clog2(NUM_ACT + 1);
  localparam int unsigned SUM_W = SCORE_W + CNT_W;
  localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'((2 ** SCORE_W) - 1);

  typedef enum logic [3:0] {
    StIdle, StLoad, StWaitAct, StCollect, StSwap, StMark, StClear, StGravity, StDone
  } state_e;

  state_e             state_q;
  logic [COLOR_W-1:0] cell_q [ROWS][COLS];
  logic [COLS-1:0]    flag_q [ROWS];
  logic [7:0]         act_q [NUM_ACT];
  logic [ACT_W-1:0]   act_cnt_q, act_idx_q;
  logic [7:0]         load_r_q, load_c_q;
  logic [SCORE_W-1:0] score_q;

  // Load write position and its raster successor; a load always starts at (0,0).
  logic [7:0] wr_r, wr_c, nx_r, nx_c;
  always_comb begin
    wr_r = (state_q == StIdle) ? 8'd0 : load_r_q;
    wr_c = (state_q == StIdle) ? 8'd0 : load_c_q;
    if (wr_c == 8'(COLS - 1)) begin
      nx_r = wr_r + 8'd1;
      nx_c = 8'd0;
    end else begin
      nx_r = wr_r;
      nx_c = wr_c + 8'd1;
    end
  end

  // Current action: {row[7:5], col[4:2], dir[1:0]}.
  logic [7:0] cur_act;
  always_comb begin
    cur_act = '0;
    for (int i = 0; i < int'(NUM_ACT); i++) begin
      if (ACT_W'(i) == act_idx_q) cur_act = act_q[i];
    end
  end

  // Swap result board; an out-of-range cell or neighbour leaves the board unchanged.
  int ar, ac, nr, nc;
  logic swap_ok;
  logic [COLOR_W-1:0] a_col, n_col;
  logic [COLOR_W-1:0] swap_cell [ROWS][COLS];
  always_comb begin
    ar = int'(cur_act[7:5]);
    ac = int'(cur_act[4:2]);
    nr = ar;
    nc = ac;
    case (cur_act[1:0])
      2'd0:    nr = ar - 1;
      2'd1:    nr = ar + 1;
      2'd2:    nc = ac - 1;
      default: nc = ac + 1;
    endcase
    swap_ok = (ar < int'(ROWS)) && (ac < int'(COLS)) && (nr >= 0) && (nr < int'(ROWS)) &&
              (nc >= 0) && (nc < int'(COLS));
    a_col = '0;
    n_col = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        if (r == ar && c == ac) a_col = cell_q[r][c];
        if (r == nr && c == nc) n_col = cell_q[r][c];
      end
    end
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        swap_cell[r][c] = cell_q[r][c];
        if (swap_ok && r == ar && c == ac) swap_cell[r][c] = n_col;
        if (swap_ok && r == nr && c == nc) swap_cell[r][c] = a_col;
      end
    end
  end

  // Run detection; flags are OR-ed so a cell in both a row and a column run counts once.
  logic [COLS-1:0]    flag_d [ROWS];
  logic [CNT_W-1:0]   flag_cnt;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;
  always_comb begin
    for (int r = 0; r < int'(ROWS); r++) flag_d[r] = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c + 2 < int'(COLS); c++) begin
        if (cell_q[r][c] != '0 && cell_q[r][c] == cell_q[r][c+1] &&
            cell_q[r][c] == cell_q[r][c+2]) begin
          flag_d[r][c] = 1'b1;
          flag_d[r][c+1] = 1'b1;
          flag_d[r][c+2] = 1'b1;
        end
      end
    end
    for (int c = 0; c < int'(COLS); c++) begin
      for (int r = 0; r + 2 < int'(ROWS); r++) begin
        if (cell_q[r][c] != '0 && cell_q[r][c] == cell_q[r+1][c] &&
            cell_q[r][c] == cell_q[r+2][c]) begin
          flag_d[r][c] = 1'b1;
          flag_d[r+1][c] = 1'b1;
          flag_d[r+2][c] = 1'b1;
        end
      end
    end
    flag_cnt = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        flag_cnt = flag_cnt + {{(CNT_W - 1){1'b0}}, flag_d[r][c]};
      end
    end
    score_sum = SUM_W'(score_q) + SUM_W'(flag_cnt);
    score_sat = (score_sum > SCORE_MAX) ? '1 : score_sum[SCORE_W-1:0];
  end

  // One gravity step: each nonzero cell above an empty cell drops one row.
  logic [COLOR_W-1:0] grav_cell [ROWS][COLS];
  logic moved;
  always_comb begin
    moved = 1'b0;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        grav_cell[r][c] = cell_q[r][c];
        if (cell_q[r][c] == '0) begin
          if (r > 0) grav_cell[r][c] = cell_q[r-1][c];
        end else if (r + 1 < int'(ROWS)) begin
          if (cell_q[r+1][c] == '0) begin
            grav_cell[r][c] = '0;
            moved = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      act_cnt_q <= '0;
      act_idx_q <= '0;
      load_r_q  <= '0;
      load_c_q  <= '0;
      score_q   <= '0;
      out_valid <= 1'b0;
      out_score <= '0;
      for (int r = 0; r < int'(ROWS); r++) begin
        flag_q[r] <= '0;
        for (int c = 0; c < int'(COLS); c++) cell_q[r][c] <= '0;
      end
      for (int i = 0; i < int'(NUM_ACT); i++) act_q[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      out_score <= '0;
      case (state_q)
        StIdle, StLoad: begin
          if (in_valid_1) begin
            if (state_q == StIdle) score_q <= '0;
            for (int r = 0; r < int'(ROWS); r++) begin
              for (int c = 0; c < int'(COLS); c++) begin
                if (state_q == StIdle) cell_q[r][c] <= '0;
                // Beats past the last cell fall off the board here.
                if (8'(r) == wr_r && 8'(c) == wr_c) cell_q[r][c] <= in_color;
              end
            end
            load_r_q <= nx_r;
            load_c_q <= nx_c;
            state_q  <= StLoad;
          end else if (state_q == StLoad) begin
            state_q <= StWaitAct;
          end
        end
        StWaitAct: begin
          if (in_valid_2) begin
            act_q[0]  <= {in_starting_pos, in_action};
            act_cnt_q <= ACT_W'(1);
            state_q   <= StCollect;
          end
        end
        StCollect: begin
          if (in_valid_2) begin
            if (act_cnt_q < ACT_W'(NUM_ACT)) begin
              for (int i = 0; i < int'(NUM_ACT); i++) begin
                if (ACT_W'(i) == act_cnt_q) act_q[i] <= {in_starting_pos, in_action};
              end
              act_cnt_q <= act_cnt_q + 1'b1;
            end
          end else begin
            act_idx_q <= '0;
            state_q   <= StSwap;
          end
        end
        StSwap: begin
          for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) cell_q[r][c] <= swap_cell[r][c];
          end
          state_q <= StMark;
        end
        StMark: begin
          for (int r = 0; r < int'(ROWS); r++) flag_q[r] <= flag_d[r];
          score_q <= score_sat;
          if (flag_cnt != '0) begin
            state_q <= StClear;
          end else if ((act_idx_q + 1'b1) == act_cnt_q) begin
            out_valid <= 1'b1;
            out_score <= score_q;
            state_q   <= StDone;
          end else begin
            act_idx_q <= act_idx_q + 1'b1;
            state_q   <= StSwap;
          end
        end
        StClear: begin
          for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
              if (flag_q[r][c]) cell_q[r][c] <= '0;
            end
          end
          state_q <= StGravity;
        end
        StGravity: begin
          for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) cell_q[r][c] <= grav_cell[r][c];
          end
          if (!moved) state_q <= StMark;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_match_engine.sv
// Directed bench for cc_match_engine: each task loads a board, issues actions and checks the
// single result pulse and score against hand-computed values.
module tb_cc_match_engine;

  localparam int WAIT_LIMIT = 1200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid_1, in_valid_2;
  logic [2:0] in_color;
  logic [5:0] in_starting_pos;
  logic [1:0] in_action;
  logic       out_valid;
  logic [6:0] out_score;

  int checks = 0;
  int failures = 0;

  logic [2:0] board [6][6];
  logic [5:0] a_pos [4];
  logic [1:0] a_dir [4];
  int n_act;

  cc_match_engine dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid_1      (in_valid_1),
    .in_valid_2      (in_valid_2),
    .in_color        (in_color),
    .in_starting_pos (in_starting_pos),
    .in_action       (in_action),
    .out_valid       (out_valid),
    .out_score       (out_score)
  );

  always #5 clk = ~clk;

  task automatic clear_board();
    for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) board[r][c] = 3'd0;
  endtask

  task automatic load_board();
    @(posedge clk); #1;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        in_valid_1 = 1'b1;
        in_color   = board[r][c];
        @(posedge clk); #1;
      end
    end
    in_valid_1 = 1'b0;
    in_color   = 3'd0;
    @(posedge clk); #1;
  endtask

  task automatic send_actions();
    for (int i = 0; i < n_act; i++) begin
      in_valid_2      = 1'b1;
      in_starting_pos = a_pos[i];
      in_action       = a_dir[i];
      @(posedge clk); #1;
    end
    in_valid_2      = 1'b0;
    in_starting_pos = 6'd0;
    in_action       = 2'd0;
  endtask

  // Observes a fixed window and reports pulse count, last pulse score and stray nonzero scores.
  task automatic wait_result(output int pulses, output int score, output int stray);
    pulses = 0;
    score  = -1;
    stray  = 0;
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        pulses++;
        score = int'(out_score);
      end else if (out_score !== 7'd0) begin
        stray++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_score !== 7'd0) begin
      failures++;
      $display("FAIL reset_out_score got=%0d exp=0", out_score);
    end
  endtask

  task automatic test_no_match();
    int p, s, st;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) board[r][c] = 3'(((r + 2 * c) % 4) + 1);
    load_board();
    n_act = 1; a_pos[0] = {3'd2, 3'd2}; a_dir[0] = 2'd3;
    send_actions();
    wait_result(p, s, st);
    checks++;
    if (p != 1) begin failures++; $display("FAIL nomatch_pulses got=%0d exp=1", p); end
    checks++;
    if (s != 0) begin failures++; $display("FAIL nomatch_score got=%0d exp=0", s); end
    checks++;
    if (st != 0) begin failures++; $display("FAIL nomatch_idle_score got=%0d exp=0", st); end
  endtask

  task automatic set_row5_board();
    clear_board();
    board[5][0] = 3'd1; board[5][1] = 3'd1; board[5][2] = 3'd2;
    board[5][3] = 3'd1; board[5][4] = 3'd3; board[5][5] = 3'd4;
  endtask

  task automatic test_simple_match();
    int p, s, st;
    set_row5_board();
    load_board();
    n_act = 1; a_pos[0] = {3'd5, 3'd2}; a_dir[0] = 2'd3;
    send_actions();
    wait_result(p, s, st);
    checks++;
    if (p != 1) begin failures++; $display("FAIL simple_pulses got=%0d exp=1", p); end
    checks++;
    if (s != 3) begin failures++; $display("FAIL simple_score got=%0d exp=3", s); end
    checks++;
    if (st != 0) begin failures++; $display("FAIL simple_idle_score got=%0d exp=0", st); end
  endtask

  task automatic test_cross();
    int p, s, st;
    clear_board();
    board[5][0] = 3'd2; board[5][1] = 3'd2; board[5][2] = 3'd3; board[5][3] = 3'd2;
    board[3][2] = 3'd2; board[4][2] = 3'd2;
    load_board();
    n_act = 1; a_pos[0] = {3'd5, 3'd2}; a_dir[0] = 2'd3;
    send_actions();
    wait_result(p, s, st);
    checks++;
    if (p != 1) begin failures++; $display("FAIL cross_pulses got=%0d exp=1", p); end
    checks++;
    if (s != 5) begin failures++; $display("FAIL cross_score got=%0d exp=5", s); end
    checks++;
    if (st != 0) begin failures++; $display("FAIL cross_idle_score got=%0d exp=0", st); end
  endtask

  task automatic set_cascade_board();
    clear_board();
    board[5][0] = 3'd1; board[5][1] = 3'd1; board[5][2] = 3'd2; board[5][3] = 3'd1;
    board[4][0] = 3'd3; board[4][1] = 3'd2; board[4][2] = 3'd2;
  endtask

  task automatic test_cascade();
    int p, s, st;
    set_cascade_board();
    load_board();
    n_act = 2;
    a_pos[0] = {3'd5, 3'd2}; a_dir[0] = 2'd3;
    a_pos[1] = {3'd0, 3'd3}; a_dir[1] = 2'd0;
    send_actions();
    wait_result(p, s, st);
    checks++;
    if (p != 1) begin failures++; $display("FAIL cascade_pulses got=%0d exp=1", p); end
    checks++;
    if (s != 6) begin failures++; $display("FAIL cascade_score got=%0d exp=6", s); end
    checks++;
    if (st != 0) begin failures++; $display("FAIL cascade_idle_score got=%0d exp=0", st); end
  endtask

  task automatic test_reset_mid_gravity();
    int p, s, st, early;
    set_cascade_board();
    load_board();
    n_act = 1; a_pos[0] = {3'd5, 3'd2}; a_dir[0] = 2'd3;
    send_actions();
    // Edges after the last beat: ->SWAP, ->MARK, ->CLEAR, ->GRAVITY.
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    early = 0;
    repeat (2) begin
      @(negedge clk);
      if (out_valid !== 1'b0) early++;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin failures++; $display("FAIL abort_no_pulse got=%0d exp=0", early); end
    set_row5_board();
    load_board();
    n_act = 1; a_pos[0] = {3'd5, 3'd2}; a_dir[0] = 2'd3;
    send_actions();
    wait_result(p, s, st);
    checks++;
    if (p != 1) begin failures++; $display("FAIL after_abort_pulses got=%0d exp=1", p); end
    checks++;
    if (s != 3) begin failures++; $display("FAIL after_abort_score got=%0d exp=3", s); end
    checks++;
    if (st != 0) begin failures++; $display("FAIL after_abort_idle_score got=%0d exp=0", st); end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
    in_color = 3'd0;
    in_starting_pos = 6'd0;
    in_action = 2'd0;
    n_act = 0;
    test_reset();
    test_no_match();
    test_simple_match();
    test_cross();
    test_cascade();
    test_reset_mid_gravity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
